// File: rtl/alu_pkg.sv
// Shared ALU definitions: default datapath geometry and add/sub operation encodings.
package alu_pkg;

  localparam int ALU_WIDTH_DEF  = 32;
  localparam int ALU_STAGES_DEF = 4;

  typedef enum logic {
    ALU_OP_ADD = 1'b0,
    ALU_OP_SUB = 1'b1
  } alu_op_e;

endpackage

// File: rtl/adder_slice.sv
// Combinational C-bit carry-chain slice; also reports the carry into its top bit for overflow.
module adder_slice #(
  parameter int C = 8
) (
  input  logic [C-1:0] a_i,
  input  logic [C-1:0] b_i,
  input  logic         ci_i,
  output logic [C-1:0] sum_o,
  output logic         co_o,
  output logic         c_msb_o
);

  logic [C:0] total;

  assign total   = {1'b0, a_i} + {1'b0, b_i} + {{C{1'b0}}, ci_i};
  assign sum_o   = total[C-1:0];
  assign co_o    = total[C];
  // Recover the carry into bit C-1 from the half-sum of that bit.
  assign c_msb_o = total[C-1] ^ a_i[C-1] ^ b_i[C-1];

endmodule

// File: rtl/pipelined_adder.sv
// Pipelined add/subtract unit: the carry chain is cut into STAGES slices, one per clock,
// with valid/ready handshaking and a global stall enable.
module pipelined_adder
  import alu_pkg::*;
#(
  parameter int WIDTH  = ALU_WIDTH_DEF,
  parameter int STAGES = ALU_STAGES_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             cout,
  output logic             overflow,
  output logic             zero
);

  localparam int C = WIDTH / STAGES;

  if ((STAGES < 1) || (STAGES > WIDTH) || ((WIDTH % STAGES) != 0)) begin : g_param_chk
    $error("pipelined_adder: WIDTH must be a positive multiple of STAGES");
  end

  logic             en;
  logic [WIDTH-1:0] b_m;
  logic             c_m;
  logic             ovf_d, zero_d;
  logic             ovf_q, zero_q;

  assign b_m = (alu_op_e'(sub) == ALU_OP_SUB) ? ~b : b;
  assign c_m = (alu_op_e'(sub) == ALU_OP_SUB) ? ~cin : cin;

  // Whole pipeline freezes while a finished result waits for the consumer.
  assign en       = !(out_valid && !out_ready);
  assign in_ready = en;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    localparam int SW = (k + 1) * C;   // sum bits resolved once this stage registers
    localparam int RW = WIDTH - SW;    // operand bits still waiting for later stages

    logic [C-1:0]  sl_a, sl_b, sl_sum;
    logic          sl_ci, sl_co, v_in;
    logic [SW-1:0] sum_d, sum_q;
    logic          c_q, v_q;

    if (k == 0) begin : g_first
      assign sl_a  = a[C-1:0];
      assign sl_b  = b_m[C-1:0];
      assign sl_ci = c_m;
      assign v_in  = in_valid;
      assign sum_d = sl_sum;
    end else begin : g_next
      assign sl_a  = g_stage[k-1].g_ops.opa_q[C-1:0];
      assign sl_b  = g_stage[k-1].g_ops.opb_q[C-1:0];
      assign sl_ci = g_stage[k-1].c_q;
      assign v_in  = g_stage[k-1].v_q;
      assign sum_d = {sl_sum, g_stage[k-1].sum_q};
    end

    if (k == STAGES - 1) begin : g_last_slice
      logic sl_cm;
      adder_slice #(.C(C)) u_slice (
        .a_i     (sl_a),
        .b_i     (sl_b),
        .ci_i    (sl_ci),
        .sum_o   (sl_sum),
        .co_o    (sl_co),
        .c_msb_o (sl_cm)
      );
    end else begin : g_mid_slice
      adder_slice #(.C(C)) u_slice (
        .a_i     (sl_a),
        .b_i     (sl_b),
        .ci_i    (sl_ci),
        .sum_o   (sl_sum),
        .co_o    (sl_co),
        .c_msb_o ()
      );
    end

    if (k < STAGES - 1) begin : g_ops
      logic [RW-1:0] opa_d, opb_d, opa_q, opb_q;

      if (k == 0) begin : g_src_in
        assign opa_d = a[WIDTH-1:C];
        assign opb_d = b_m[WIDTH-1:C];
      end else begin : g_src_prev
        assign opa_d = g_stage[k-1].g_ops.opa_q[RW+C-1:C];
        assign opb_d = g_stage[k-1].g_ops.opb_q[RW+C-1:C];
      end

      always_ff @(posedge clk) begin
        if (rst) begin
          opa_q <= '0;
          opb_q <= '0;
        end else if (en) begin
          opa_q <= opa_d;
          opb_q <= opb_d;
        end
      end
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        v_q   <= 1'b0;
        sum_q <= '0;
        c_q   <= 1'b0;
      end else if (en) begin
        v_q   <= v_in;
        sum_q <= sum_d;
        c_q   <= sl_co;
      end
    end
  end

  assign ovf_d  = g_stage[STAGES-1].g_last_slice.sl_cm ^ g_stage[STAGES-1].sl_co;
  assign zero_d = ~|g_stage[STAGES-1].sum_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_q  <= 1'b0;
      zero_q <= 1'b0;
    end else if (en) begin
      ovf_q  <= ovf_d;
      zero_q <= zero_d;
    end
  end

  assign out_valid = g_stage[STAGES-1].v_q;
  assign s         = g_stage[STAGES-1].sum_q;
  assign cout      = g_stage[STAGES-1].c_q;
  assign overflow  = ovf_q;
  assign zero      = zero_q;

endmodule

// File: tb/tb_pipelined_adder.sv
// Directed self-checking bench for pipelined_adder (WIDTH=32, STAGES=4).
module tb_pipelined_adder;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready;
  logic [31:0] a, b;
  logic        cin, sub;
  logic        out_valid, out_ready;
  logic [31:0] s;
  logic        cout, overflow, zero;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  pipelined_adder #(.WIDTH(32), .STAGES(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .s         (s),
    .cout      (cout),
    .overflow  (overflow),
    .zero      (zero)
  );

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference arithmetic written from the signed/unsigned definitions: {ovf, cout, s}.
  function automatic logic [33:0] golden(input logic [31:0] x, input logic [31:0] y,
                                         input logic c, input logic op);
    logic [32:0] r;
    logic        v;
    if (op) begin
      r = {1'b0, x} - {1'b0, y} - {32'd0, c};
      v = (x[31] != y[31]) && (r[31] != x[31]);
      return {v, ~r[32], r[31:0]};
    end else begin
      r = {1'b0, x} + {1'b0, y} + {32'd0, c};
      v = (x[31] == y[31]) && (r[31] != x[31]);
      return {v, r[32], r[31:0]};
    end
  endfunction

  task automatic run_one(input string tag, input logic [31:0] ta, input logic [31:0] tb,
                         input logic tc, input logic ts, input logic [31:0] es,
                         input logic ec, input logic eo, input logic ez);
    int n;
    a = ta; b = tb; cin = tc; sub = ts;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    check_val({tag, "_inrdy"}, 64'(in_ready), 64'd1);
    step();
    in_valid = 1'b0;
    n = 1;
    while (!out_valid && n < 20) begin
      step();
      n++;
    end
    check_val({tag, "_lat"},  64'(n),         64'd4);
    check_val({tag, "_s"},    64'(s),         64'(es));
    check_val({tag, "_cout"}, 64'(cout),      64'(ec));
    check_val({tag, "_ovf"},  64'(overflow),  64'(eo));
    check_val({tag, "_zero"}, 64'(zero),      64'(ez));
    step();
    check_val({tag, "_drain"}, 64'(out_valid), 64'd0);
  endtask

  logic [31:0] va [8];
  logic [31:0] vb [8];
  logic        vc [8];
  logic        vs [8];
  logic [33:0] ve [8];

  initial begin
    int          sent, got, vcount;
    logic        stalled_prev, stall, fire_in, fire_out;
    logic [31:0] held_s;

    // Reset with a live beat offered: nothing may enter.
    rst = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
    a = 32'hDEAD_BEEF; b = 32'h1234_5678; cin = 1'b1; sub = 1'b0;
    step();
    step();
    check_val("rst_ovalid", 64'(out_valid), 64'd0);
    check_val("rst_s",      64'(s),         64'd0);
    check_val("rst_cout",   64'(cout),      64'd0);
    check_val("rst_ovf",    64'(overflow),  64'd0);
    check_val("rst_zero",   64'(zero),      64'd0);
    rst = 1'b0; in_valid = 1'b0;
    step();
    check_val("rst_inrdy",  64'(in_ready),  64'd1);
    check_val("rst_idle",   64'(out_valid), 64'd0);

    run_one("add",     32'd100,        32'd23,  1'b1, 1'b0, 32'd124,        1'b0, 1'b0, 1'b0);
    run_one("ripple",  32'hFFFF_FFFF,  32'd1,   1'b0, 1'b0, 32'h0000_0000,  1'b1, 1'b0, 1'b1);
    run_one("posovf",  32'h7FFF_FFFF,  32'd1,   1'b0, 1'b0, 32'h8000_0000,  1'b0, 1'b1, 1'b0);
    run_one("subneg",  32'd5,          32'd7,   1'b0, 1'b1, 32'hFFFF_FFFE,  1'b0, 1'b0, 1'b0);
    run_one("subovf",  32'h8000_0000,  32'd1,   1'b0, 1'b1, 32'h7FFF_FFFF,  1'b1, 1'b1, 1'b0);
    run_one("subbrw",  32'd10,         32'd3,   1'b1, 1'b1, 32'd6,          1'b1, 1'b0, 1'b0);

    // Back-to-back beats with the consumer stalling in windows 5..8.
    for (int i = 0; i < 8; i++) begin
      va[i] = $urandom;
      vb[i] = $urandom;
      vc[i] = 1'($urandom_range(1, 0));
      vs[i] = 1'($urandom_range(1, 0));
      ve[i] = golden(va[i], vb[i], vc[i], vs[i]);
    end
    sent = 0; got = 0; stalled_prev = 1'b0; held_s = '0;
    for (int w = 0; w < 60 && got < 8; w++) begin
      out_ready = !(w >= 5 && w <= 8);
      in_valid  = (sent < 8);
      if (sent < 8) begin
        a = va[sent]; b = vb[sent]; cin = vc[sent]; sub = vs[sent];
      end
      #1;
      if (stalled_prev) begin
        check_val("bp_hold_v", 64'(out_valid), 64'd1);
        check_val("bp_hold_s", 64'(s),         64'(held_s));
      end
      stall = out_valid && !out_ready;
      if (stall) check_val("bp_inrdy", 64'(in_ready), 64'd0);
      fire_in  = in_valid && in_ready;
      fire_out = out_valid && out_ready;
      if (fire_out) begin
        check_val("bp_s",    64'(s),        64'(ve[got][31:0]));
        check_val("bp_cout", 64'(cout),     64'(ve[got][32]));
        check_val("bp_ovf",  64'(overflow), 64'(ve[got][33]));
        got++;
      end
      held_s       = s;
      stalled_prev = stall;
      step();
      if (fire_in) sent++;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    check_val("bp_sent", 64'(sent), 64'd8);
    check_val("bp_got",  64'(got),  64'd8);

    // Three beats in flight, then a reset pulse flushes them.
    step();
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; a = 32'(i + 1); b = 32'd1000; cin = 1'b0; sub = 1'b0;
      step();
    end
    in_valid = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    check_val("flush_inrdy", 64'(in_ready), 64'd1);
    vcount = 0;
    for (int i = 0; i < 8; i++) begin
      if (out_valid) vcount++;
      step();
    end
    check_val("flush_none", 64'(vcount), 64'd0);
    run_one("postrst", 32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0, 32'h2345_6789, 1'b0, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
